// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MIPS memory stage.
// Decodes the load/store opcode and checks alignment. Aligned accesses are
// held for LATENCY stall cycles and then committed to an internal 32-bit RAM
// (stores) or captured into readdataM with sign/zero extension (loads).
// Ports:
//   clk, rst    - rising-edge clock, asynchronous active-high reset
//   req_valid   - memory-stage instruction valid (not flushed)
//   opM         - MIPS opcode of the memory-stage instruction
//   aluoutM     - effective byte address
//   writedataM  - right-aligned store data
//   readdataM   - extended load result, held until the next load commits
//   adel_rdM    - misaligned load (combinational)
//   adesM       - misaligned store (combinational)
//   stall_mem   - pipeline hold request
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [5:0]  opM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        adel_rdM,
  output logic        adesM,
  output logic        stall_mem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        stall, commit;

  logic        is_load, is_store, sext, misaligned, aligned_req;
  size_t       size;
  logic [1:0]  lane;
  logic [DEPTH_LOG2-1:0] idx;

  logic [31:0] mem [2**DEPTH_LOG2];
  logic [31:0] wdata, rword, rshift, rext;
  logic [3:0]  be;

  assign lane = aluoutM[1:0];
  assign idx  = aluoutM[DEPTH_LOG2+1:2];

  // Address bits above the RAM index are intentionally ignored (wrap-around).
  logic unused_addr;
  assign unused_addr = ^aluoutM[31:DEPTH_LOG2+2];

  // Opcode decode
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    size     = SZ_WORD;
    unique case (opM)
      6'b100000: begin is_load  = 1'b1; sext = 1'b1; size = SZ_BYTE; end // LB
      6'b100100: begin is_load  = 1'b1;              size = SZ_BYTE; end // LBU
      6'b100001: begin is_load  = 1'b1; sext = 1'b1; size = SZ_HALF; end // LH
      6'b100101: begin is_load  = 1'b1;              size = SZ_HALF; end // LHU
      6'b100011: begin is_load  = 1'b1;              size = SZ_WORD; end // LW
      6'b101000: begin is_store = 1'b1;              size = SZ_BYTE; end // SB
      6'b101001: begin is_store = 1'b1;              size = SZ_HALF; end // SH
      6'b101011: begin is_store = 1'b1;              size = SZ_WORD; end // SW
      default:   ;
    endcase
  end

  always_comb begin
    unique case (size)
      SZ_HALF: misaligned = lane[0];
      SZ_WORD: misaligned = |lane;
      default: misaligned = 1'b0;
    endcase
  end

  assign aligned_req = req_valid & (is_load | is_store) & ~misaligned;
  assign adel_rdM    = ~rst & req_valid & is_load  & misaligned;
  assign adesM       = ~rst & req_valid & is_store & misaligned;

  // Access FSM: the accept cycle plus LATENCY-1 BUSY cycles form the stall
  // window; commit fires on the transition into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (aligned_req) begin
          stall   = 1'b1;
          cnt_nxt = LAT_M1;
          if (LATENCY > 1) begin
            state_nxt = BUSY;
          end else begin
            state_nxt = DONE;
            commit    = 1'b1;
          end
        end
      end
      BUSY: begin
        if (!req_valid) begin
          // Flushed while waiting: cancel without side effects.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          stall   = 1'b1;
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_nxt = DONE;
            commit    = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_mem = stall & ~rst;

  // Store lane steering: replicate the right-aligned data across lanes and
  // let the byte enables pick the target.
  always_comb begin
    unique case (size)
      SZ_BYTE: begin
        wdata = {4{writedataM[7:0]}};
        be    = 4'b0001 << lane;
      end
      SZ_HALF: begin
        wdata = {2{writedataM[15:0]}};
        be    = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = writedataM;
        be    = 4'b1111;
      end
    endcase
  end

  // RAM contents survive reset; only the commit itself is suppressed.
  always_ff @(posedge clk) begin
    if (commit && is_store && !rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  assign rword  = mem[idx];
  assign rshift = rword >> {lane, 3'b000};

  always_comb begin
    unique case (size)
      SZ_BYTE: rext = sext ? {{24{rshift[7]}},  rshift[7:0]}  : {24'h0, rshift[7:0]};
      SZ_HALF: rext = sext ? {{16{rshift[15]}}, rshift[15:0]} : {16'h0, rshift[15:0]};
      default: rext = rword;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdataM <= '0;
    end else if (commit && is_load) begin
      readdataM <= rext;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [5:0]  opM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        adel_rdM;
  logic        adesM;
  logic        stall_mem;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [5:0] LB  = 6'b100000, LBU = 6'b100100, LH = 6'b100001,
                         LHU = 6'b100101, LW  = 6'b100011, SB = 6'b101000,
                         SH  = 6'b101001, SW  = 6'b101011, ADD = 6'b000000;

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .opM        (opM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .adel_rdM   (adel_rdM),
    .adesM      (adesM),
    .stall_mem  (stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request (called just after a rising edge) and holds it until
  // stall_mem is low at a falling edge. Reports the stall count, the readback
  // in the first non-stalled cycle and the error flags of the first cycle.
  // A request that never releases comes back with stalls = 20.
  task automatic access(input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, output int stalls,
                        output logic [31:0] rd, output logic adel,
                        output logic ades);
    req_valid  = 1'b1;
    opM        = op;
    aluoutM    = addr;
    writedataM = wd;
    stalls     = 0;
    rd         = 'x;
    adel       = 1'b0;
    ades       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        adel = adel_rdM;
        ades = adesM;
      end
      if (!stall_mem) begin
        rd = readdataM;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    opM       = ADD;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; opM = LH; aluoutM = 32'h13; writedataM = '0;
    #2;
    tests_run++;
    if ({readdataM, stall_mem, adel_rdM, adesM} !== 35'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rd=%h st=%b adel=%b ades=%b, want 0", readdataM, stall_mem, adel_rdM, adesM);
    end
    req_valid = 1'b0; opM = ADD;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    int st; logic [31:0] rd; logic el, es;
    access(SW, 32'h10, 32'h11223344, st, rd, el, es);
    tests_run++;
    if (st !== 2) begin tests_failed++; $display("FAIL sw_stalls: got %0d want 2", st); end
    access(LW, 32'h10, 32'h0, st, rd, el, es);
    tests_run++;
    if (st !== 2) begin tests_failed++; $display("FAIL lw_stalls: got %0d want 2", st); end
    tests_run++;
    if (rd !== 32'h11223344) begin tests_failed++; $display("FAIL lw_data: got %h want 11223344", rd); end
  endtask

  task automatic test_subword();
    int st; logic [31:0] rd; logic el, es;
    access(SB, 32'h11, 32'h000000AA, st, rd, el, es);
    tests_run++;
    if (rd !== 32'h11223344) begin tests_failed++; $display("FAIL store_holds_rd: got %h want 11223344", rd); end
    access(LW, 32'h10, 32'h0, st, rd, el, es);
    tests_run++;
    if (rd !== 32'h1122AA44) begin tests_failed++; $display("FAIL sb_merge: got %h want 1122aa44", rd); end
    access(LB, 32'h11, 32'h0, st, rd, el, es);
    tests_run++;
    if (rd !== 32'hFFFFFFAA) begin tests_failed++; $display("FAIL lb_sext: got %h want ffffffaa", rd); end
    access(LBU, 32'h11, 32'h0, st, rd, el, es);
    tests_run++;
    if (rd !== 32'h000000AA) begin tests_failed++; $display("FAIL lbu_zext: got %h want 000000aa", rd); end
    access(LHU, 32'h10, 32'h0, st, rd, el, es);
    tests_run++;
    if (rd !== 32'h0000AA44) begin tests_failed++; $display("FAIL lhu_lo: got %h want 0000aa44", rd); end
    access(LH, 32'h10, 32'h0, st, rd, el, es);
    tests_run++;
    if (rd !== 32'hFFFFAA44) begin tests_failed++; $display("FAIL lh_lo: got %h want ffffaa44", rd); end
    access(SH, 32'h12, 32'hFFFF8001, st, rd, el, es);
    access(LW, 32'h10, 32'h0, st, rd, el, es);
    tests_run++;
    if (rd !== 32'h8001AA44) begin tests_failed++; $display("FAIL sh_merge: got %h want 8001aa44", rd); end
    access(LH, 32'h12, 32'h0, st, rd, el, es);
    tests_run++;
    if (rd !== 32'hFFFF8001) begin tests_failed++; $display("FAIL lh_hi: got %h want ffff8001", rd); end
    access(LB, 32'h13, 32'h0, st, rd, el, es);
    tests_run++;
    if (rd !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL lb_lane3: got %h want ffffff80", rd); end
  endtask

  task automatic test_misaligned();
    int st; logic [31:0] rd; logic el, es;
    access(LH, 32'h13, 32'h0, st, rd, el, es);
    tests_run++;
    if ({el, es, st} !== {1'b1, 1'b0, 32'd0}) begin
      tests_failed++; $display("FAIL lh_misaligned: got adel=%b ades=%b stalls=%0d want 1 0 0", el, es, st);
    end
    tests_run++;
    if (readdataM !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL misaligned_rd_hold: got %h want ffffff80", readdataM); end
    access(SW, 32'h20, 32'h01020304, st, rd, el, es);
    access(SW, 32'h22, 32'h55555555, st, rd, el, es);
    tests_run++;
    if ({el, es, st} !== {1'b0, 1'b1, 32'd0}) begin
      tests_failed++; $display("FAIL sw_misaligned: got adel=%b ades=%b stalls=%0d want 0 1 0", el, es, st);
    end
    access(LW, 32'h20, 32'h0, st, rd, el, es);
    tests_run++;
    if (rd !== 32'h01020304) begin tests_failed++; $display("FAIL sw_misaligned_nowrite: got %h want 01020304", rd); end
    access(ADD, 32'h10, 32'h0, st, rd, el, es);
    tests_run++;
    if ({el, es, st} !== {1'b0, 1'b0, 32'd0}) begin
      tests_failed++; $display("FAIL non_mem_op: got adel=%b ades=%b stalls=%0d want 0 0 0", el, es, st);
    end
  endtask

  task automatic test_flush();
    int st; logic [31:0] rd; logic el, es;
    access(SW, 32'h10, 32'hDEADBEEF, st, rd, el, es);
    req_valid = 1'b1; opM = SW; aluoutM = 32'h10; writedataM = 32'h12345678;
    @(negedge clk);
    tests_run++;
    if (stall_mem !== 1'b1) begin tests_failed++; $display("FAIL flush_accept: got stall=%b want 1", stall_mem); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    tests_run++;
    if (stall_mem !== 1'b0) begin tests_failed++; $display("FAIL flush_stall_drop: got stall=%b want 0", stall_mem); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    access(LW, 32'h10, 32'h0, st, rd, el, es);
    tests_run++;
    if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL flush_nowrite: got %h want deadbeef", rd); end
  endtask

  task automatic test_reset_mid_access();
    int st; logic [31:0] rd; logic el, es;
    access(LW, 32'h20, 32'h0, st, rd, el, es);
    req_valid = 1'b1; opM = LW; aluoutM = 32'h10;
    @(posedge clk); #1;
    tests_run++;
    if (stall_mem !== 1'b1) begin tests_failed++; $display("FAIL busy_before_reset: got stall=%b want 1", stall_mem); end
    opM = LH; aluoutM = 32'h13;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({readdataM, stall_mem, adel_rdM, adesM} !== 35'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_access: got rd=%h st=%b adel=%b ades=%b, want 0", readdataM, stall_mem, adel_rdM, adesM);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; opM = ADD;
    @(posedge clk); #1;
    access(LW, 32'h10, 32'h0, st, rd, el, es);
    tests_run++;
    if (st !== 2 || rd !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL after_reset_access: got stalls=%0d rd=%h want 2 deadbeef", st, rd);
    end
  endtask

  task automatic test_wrap();
    int st; logic [31:0] rd; logic el, es;
    access(SW, 32'h400, 32'hCAFEF00D, st, rd, el, es);
    access(LW, 32'h000, 32'h0, st, rd, el, es);
    tests_run++;
    if (rd !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL wrap_around: got %h want cafef00d", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_misaligned();
    test_flush();
    test_reset_mid_access();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
